// File: rtl/adder_arbiter_pkg.sv
// adder_arb_pkg: shared definitions for the adder_arbiter slice.
//   state_t       - arbiter FSM states (IDLE, BURST)
//   N_DEF         - default operand/sum width
//   NREQ_DEF      - default number of requesters
//   MAX_BURST_DEF - default beat limit per grant
package adder_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int N_DEF         = 23;
  localparam int NREQ_DEF      = 4;
  localparam int MAX_BURST_DEF = 20;

endpackage

// File: rtl/adder_arbiter_adder.sv
// adder: N-bit combinational adder shared by all requesters.
// The carry-out is dropped, so the sum wraps modulo 2^N.
//   input1 [N-1:0] - operand A
//   input2 [N-1:0] - operand B
//   sum    [N-1:0] - (input1 + input2) mod 2^N
module adder
  import adder_arb_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic [N-1:0] sum
);

  assign sum = input1 + input2;

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin scheduler sharing one adder between NREQ
// requesters. One requester is granted per burst; its beats pass through
// the adder into a single registered, tagged valid/ready result port.
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_last  - per-requester beat valid / last-beat marker
//   req_in1/req_in2     - packed operands, requester k at [k*N +: N]
//   req_ready           - per-requester beat accept
//   res_valid/res_ready - result handshake
//   res_sum/res_id      - wrapped sum and the requester that produced it
//   res_last            - final beat of the burst (last or beat limit)
//   busy                - high while a burst is granted
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int N         = N_DEF,
  parameter  int NREQ      = NREQ_DEF,
  parameter  int MAX_BURST = MAX_BURST_DEF,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*N-1:0] req_in1,
  input  logic [NREQ*N-1:0] req_in2,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_sum,
  output logic [IDW-1:0]    res_id,
  output logic              res_last,
  output logic              busy
);

  localparam int              CNTW     = $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAX_BURST - 1);
  localparam logic [IDW-1:0]  GNT_TOP  = IDW'(NREQ - 1);

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  rr_ptr;
  logic [CNTW-1:0] beat_cnt;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  int              rr_idx;

  logic            sel_valid_p0;
  logic            sel_last_p0;
  logic [N-1:0]    in1_p0;
  logic [N-1:0]    in2_p0;
  logic [N-1:0]    sum_p0;
  logic            out_free_p0;
  logic            accept_p0;
  logic            last_p0;

  logic            vld_p1;
  logic [N-1:0]    sum_p1;
  logic [IDW-1:0]  id_p1;
  logic            last_p1;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin : rr_search
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      rr_idx = int'(rr_ptr) + i;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      if (!win_found && req_valid[IDW'(rr_idx)]) begin
        win_found = 1'b1;
        win_id    = IDW'(rr_idx);
      end
    end
  end

  // ---- stage p0: gnt-indexed operand mux feeding the shared adder ----
  always_comb begin : operand_mux
    sel_valid_p0 = 1'b0;
    sel_last_p0  = 1'b0;
    in1_p0       = '0;
    in2_p0       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt == IDW'(k)) begin
        sel_valid_p0 = req_valid[k];
        sel_last_p0  = req_last[k];
        in1_p0       = req_in1[k*N +: N];
        in2_p0       = req_in2[k*N +: N];
      end
    end
  end

  adder #(.N(N)) u_adder (
    .input1 (in1_p0),
    .input2 (in2_p0),
    .sum    (sum_p0)
  );

  // The output slot is free when empty or being drained this cycle, so a
  // new beat can overwrite a consumed result without a bubble.
  assign out_free_p0 = !vld_p1 || res_ready;
  assign accept_p0   = (state == BURST) && sel_valid_p0 && out_free_p0;
  assign last_p0     = sel_last_p0 || (beat_cnt == CNT_LAST);

  always_comb begin : ready_gen
    req_ready = '0;
    if (state == BURST) begin
      for (int k = 0; k < NREQ; k++) begin
        if (gnt == IDW'(k)) req_ready[k] = out_free_p0;
      end
    end
  end

  always_comb begin : fsm_next
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = BURST;
      BURST:   if (accept_p0 && last_p0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : fsm_reg
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin : grant_ctrl
    if (rst) begin
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (win_found) begin
        gnt      <= win_id;
        beat_cnt <= '0;
      end
    end else if (accept_p0) begin
      beat_cnt <= beat_cnt + CNTW'(1);
      if (last_p0) rr_ptr <= (gnt == GNT_TOP) ? '0 : gnt + IDW'(1);
    end
  end

  // ---- stage p1: registered, tagged result ----
  always_ff @(posedge clk) begin : result_reg
    if (rst) begin
      vld_p1  <= 1'b0;
      sum_p1  <= '0;
      id_p1   <= '0;
      last_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      sum_p1  <= sum_p0;
      id_p1   <= gnt;
      last_p1 <= last_p0;
    end else if (res_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign res_valid = vld_p1;
  assign res_sum   = sum_p1;
  assign res_id    = id_p1;
  assign res_last  = last_p1;
  assign busy      = (state == BURST);

endmodule
